pacman_input_ctrl: RTL

Upstream stage of `pacman_game`. Conditions the four raw board push-buttons: synchronises, debounces, edge-detects, and optionally latches the last pressed direction. Presents one-hot `BTNU/BTND/BTNR/BTNL` that only change immediately after a `frame_stb` edge, so the game's 60 Hz movement logic never sees a mid-frame direction change.

---
 rtl/pacman_input_ctrl_if.sv | 37 +++
 rtl/pacman_input_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pacman_input_ctrl_if.sv
// Button-conditioning bus between the board/bench side and pacman_input_ctrl.
// The master drives raw buttons and the frame strobe; the slave returns conditioned levels and direction.
interface pacman_input_ctrl_if;
  logic [3:0] btn_raw;
  logic       frame_stb;
  logic [3:0] btn_db;
  logic [3:0] btn_press;
  logic       BTNU;
  logic       BTND;
  logic       BTNR;
  logic       BTNL;
  logic       dir_valid;

  modport master (
    output btn_raw,
    output frame_stb,
    input  btn_db,
    input  btn_press,
    input  BTNU,
    input  BTND,
    input  BTNR,
    input  BTNL,
    input  dir_valid
  );

  modport slave (
    input  btn_raw,
    input  frame_stb,
    output btn_db,
    output btn_press,
    output BTNU,
    output BTND,
    output BTNR,
    output BTNL,
    output dir_valid
  );
endinterface

// File: rtl/pacman_input_ctrl.sv
// Push-button conditioner for pacman_game: sync, debounce, press detect, and a direction
// that only changes on frame_stb so movement never sees a mid-frame turn.
module pacman_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit LATCH           = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  pacman_input_ctrl_if.slave bus
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    RIGHT = 3'd3,
    LEFT  = 3'd4
  } dir_e;

  // U > D > R > L when several bits are set together.
  function automatic dir_e prio_dir(input logic [3:0] b);
    if (b[3])      return UP;
    else if (b[2]) return DOWN;
    else if (b[1]) return RIGHT;
    else if (b[0]) return LEFT;
    else           return IDLE;
  endfunction

  logic [3:0]       s1_p0;
  logic [3:0]       s2_p1;
  logic [CNT_W-1:0] cnt_p2  [4];
  logic [CNT_W-1:0] cnt_next[4];
  logic [3:0]       db_p2;
  logic [3:0]       db_next;
  logic [3:0]       press_p3;
  dir_e             pend_p4;
  dir_e             pend_next;
  logic             btnu_q;
  logic             btnd_q;
  logic             btnr_q;
  logic             btnl_q;
  logic             dir_valid_q;

  // Stage p0/p1: two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0 <= '0;
      s2_p1 <= '0;
    end else begin
      s1_p0 <= bus.btn_raw;
      s2_p1 <= s1_p0;
    end
  end

  // Stage p2: per-bit debounce; any agreeing cycle restarts the count.
  always_comb begin
    db_next = db_p2;
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = '0;
      if (s2_p1[i] != db_p2[i]) begin
        if (cnt_p2[i] == CNT_LAST) begin
          db_next[i] = s2_p1[i];
        end else begin
          cnt_next[i] = cnt_p2[i] + CNT_ONE;
        end
      end
    end
  end

  // Stage p3: press pulse is registered alongside the debounced level it came from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p2   <= '{default: '0};
      db_p2    <= '0;
      press_p3 <= '0;
    end else begin
      cnt_p2   <= cnt_next;
      db_p2    <= db_next;
      press_p3 <= db_next & ~db_p2;
    end
  end

  always_comb begin
    pend_next = pend_p4;
    if (LATCH) begin
      if (|press_p3) begin
        pend_next = prio_dir(press_p3);
      end
    end else begin
      pend_next = prio_dir(db_p2);
    end
  end

  // Stage p4: pending direction, committed to the outputs only on frame_stb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p4     <= IDLE;
      btnu_q      <= 1'b0;
      btnd_q      <= 1'b0;
      btnr_q      <= 1'b0;
      btnl_q      <= 1'b0;
      dir_valid_q <= 1'b0;
    end else begin
      pend_p4 <= pend_next;
      if (bus.frame_stb) begin
        btnu_q      <= (pend_next == UP);
        btnd_q      <= (pend_next == DOWN);
        btnr_q      <= (pend_next == RIGHT);
        btnl_q      <= (pend_next == LEFT);
        dir_valid_q <= (pend_next != IDLE);
      end
    end
  end

  assign bus.btn_db    = db_p2;
  assign bus.btn_press = press_p3;
  assign bus.BTNU      = btnu_q;
  assign bus.BTND      = btnd_q;
  assign bus.BTNR      = btnr_q;
  assign bus.BTNL      = btnl_q;
  assign bus.dir_valid = dir_valid_q;

endmodule
